// File: rtl/deser_pkg.sv
// Shared types for the serial-to-parallel receiver: FSM state encoding and
// the bit-order selector values used by the LSB_FIRST parameter.
package deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam bit ORDER_MSB_FIRST = 1'b0;
  localparam bit ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_to_parallel_deser_if.sv
// Serial-in / word-out bundle of the receiver. The master side feeds bits and
// consumes words; the slave side is the deserializer itself.
interface serial_to_parallel_deser_if #(
  parameter int WIDTH = 128
);

  logic             ser_bit;
  logic             ser_valid;
  logic             ser_start;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             clr_ovr;

  modport master (
    output ser_bit, ser_valid, ser_start, out_ready, clr_ovr,
    input  out_data, out_valid, busy, frame_err, overrun
  );

  modport slave (
    input  ser_bit, ser_valid, ser_start, out_ready, clr_ovr,
    output out_data, out_valid, busy, frame_err, overrun
  );

endinterface

// File: rtl/deser_out_stage.sv
// Holding register for the last completed word with its valid/ready handshake
// and the sticky overrun flag raised when a finished word finds the slot full.
module deser_out_stage #(
  parameter int WIDTH = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             overrun_reg;
  logic             slot_free;

  // A word being taken this cycle frees the slot for a word completing this cycle.
  assign slot_free = !valid_reg || out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (load && slot_free) begin
        data_reg  <= word;
        valid_reg <= 1'b1;
      end else if (valid_reg && out_ready) begin
        valid_reg <= 1'b0;
      end

      if (load && !slot_free) begin
        overrun_reg <= 1'b1;
      end else if (clr_ovr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/serial_to_parallel_deser.sv
// Rebuilds WIDTH-bit words from a 1-bit stream; the shifter fills the next
// word while the previous one waits in the output stage.
module serial_to_parallel_deser
  import deser_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter bit LSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic                        clock,
  input  logic                        reset,
  serial_to_parallel_deser_if.slave   bus
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] sh_reg;
  logic [WIDTH-1:0] sh_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             frame_err_reg;
  logic             load;

  generate
    if (LSB_FIRST == ORDER_LSB_FIRST) begin : g_lsb_first
      assign sh_next = {bus.ser_bit, sh_reg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign sh_next = {sh_reg[WIDTH-2:0], bus.ser_bit};
    end
  endgenerate

  // The completed word is the shifter including the bit accepted this cycle.
  assign load = bus.ser_valid && !bus.ser_start &&
                (state_reg == SHIFT) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      sh_reg        <= '0;
      cnt_reg       <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      if (bus.ser_valid) begin
        sh_reg <= sh_next;
        if ((state_reg == IDLE) || bus.ser_start) begin
          // Stale bits left in the shifter are pushed out before the word completes.
          cnt_reg       <= CNT_W'(1);
          state_reg     <= SHIFT;
          frame_err_reg <= (state_reg == SHIFT);
        end else if (load) begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (state_reg == SHIFT);
  assign bus.frame_err = frame_err_reg;

  deser_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .word      (sh_next),
    .out_ready (bus.out_ready),
    .clr_ovr   (bus.clr_ovr),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .overrun   (bus.overrun)
  );

endmodule

// File: tb/tb_serial_to_parallel_deser.sv
// Bench for serial_to_parallel_deser: 8-bit LSB-first, 8-bit MSB-first and
// 128-bit instances, table-driven streams plus hand-written corner sequences.
module tb_serial_to_parallel_deser;
  import deser_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a, rst_b, rst_c;

  serial_to_parallel_deser_if #(.WIDTH(8))   ia ();
  serial_to_parallel_deser_if #(.WIDTH(8))   ib ();
  serial_to_parallel_deser_if #(.WIDTH(128)) ic ();

  serial_to_parallel_deser #(.WIDTH(8), .LSB_FIRST(ORDER_LSB_FIRST)) dut_a (
    .clock (clock), .reset (rst_a), .bus (ia.slave)
  );
  serial_to_parallel_deser #(.WIDTH(8), .LSB_FIRST(ORDER_MSB_FIRST)) dut_b (
    .clock (clock), .reset (rst_b), .bus (ib.slave)
  );
  serial_to_parallel_deser #(.WIDTH(128), .LSB_FIRST(ORDER_LSB_FIRST)) dut_c (
    .clock (clock), .reset (rst_c), .bus (ic.slave)
  );

  typedef struct packed {
    logic [7:0] stream;   // stream[0] is sent first
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
    bit         gap;      // insert an idle cycle after bit 3
  } vec_t;

  vec_t         vecs [6];
  logic [7:0]   q_a [$];
  logic [7:0]   q_b [$];
  logic [127:0] q_c [$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           fe_a     = 0;
  int           fe_b     = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got word %h required no word", name, act);
  endtask

  // Scoreboard side: a word is checked on the cycle it is handed over.
  always @(negedge clock) begin
    if (ia.frame_err) fe_a++;
    if (ib.frame_err) fe_b++;
    if (ia.out_valid && ia.out_ready) begin
      if (q_a.size() == 0) unexpected("a_word", 128'(ia.out_data));
      else check("a_word", 128'(ia.out_data), 128'(q_a.pop_front()));
    end
    if (ib.out_valid && ib.out_ready) begin
      if (q_b.size() == 0) unexpected("b_word", 128'(ib.out_data));
      else check("b_word", 128'(ib.out_data), 128'(q_b.pop_front()));
    end
    if (ic.out_valid && ic.out_ready) begin
      if (q_c.size() == 0) unexpected("c_word", ic.out_data);
      else check("c_word", ic.out_data, q_c.pop_front());
    end
  end

  task automatic drv(input logic b, input logic st, input bit to_a, input bit to_b);
    @(posedge clock); #1;
    ia.ser_valid = to_a; ia.ser_bit = b; ia.ser_start = st;
    ib.ser_valid = to_b; ib.ser_bit = b; ib.ser_start = st;
  endtask

  task automatic drv_c(input logic b);
    @(posedge clock); #1;
    ic.ser_valid = 1'b1; ic.ser_bit = b; ic.ser_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      ia.ser_valid = 1'b0; ia.ser_start = 1'b0;
      ib.ser_valid = 1'b0; ib.ser_start = 1'b0;
      ic.ser_valid = 1'b0; ic.ser_start = 1'b0;
    end
  endtask

  task automatic send_a(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drv(w[i], 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0]   w;
    logic [127:0] wc;

    vecs[0] = '{stream: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5, gap: 1'b0};
    vecs[1] = '{stream: 8'h80, exp_lsb: 8'h80, exp_msb: 8'h01, gap: 1'b0};
    vecs[2] = '{stream: 8'h0F, exp_lsb: 8'h0F, exp_msb: 8'hF0, gap: 1'b1};
    vecs[3] = '{stream: 8'h12, exp_lsb: 8'h12, exp_msb: 8'h48, gap: 1'b0};
    vecs[4] = '{stream: 8'hFF, exp_lsb: 8'hFF, exp_msb: 8'hFF, gap: 1'b1};
    vecs[5] = '{stream: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80, gap: 1'b0};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ia.ser_bit = 1'b0; ia.ser_valid = 1'b0; ia.ser_start = 1'b0; ia.out_ready = 1'b1; ia.clr_ovr = 1'b0;
    ib.ser_bit = 1'b0; ib.ser_valid = 1'b0; ib.ser_start = 1'b0; ib.out_ready = 1'b1; ib.clr_ovr = 1'b0;
    ic.ser_bit = 1'b0; ic.ser_valid = 1'b0; ic.ser_start = 1'b0; ic.out_ready = 1'b1; ic.clr_ovr = 1'b0;

    #12;
    check("a_reset", 128'({ia.out_data, ia.out_valid, ia.busy, ia.frame_err, ia.overrun}), 128'(0));
    check("b_reset", 128'({ib.out_data, ib.out_valid, ib.busy, ib.frame_err, ib.overrun}), 128'(0));
    check("c_reset_data", ic.out_data, 128'(0));
    check("c_reset_flags", 128'({ic.out_valid, ic.busy, ic.frame_err, ic.overrun}), 128'(0));
    #10;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Table: same stream into both 8-bit instances, back to back, ser_start on bit 0.
    for (int v = 0; v < 6; v++) begin
      q_a.push_back(vecs[v].exp_lsb);
      q_b.push_back(vecs[v].exp_msb);
      for (int i = 0; i < 8; i++) begin
        drv(vecs[v].stream[i], (i == 0), 1'b1, 1'b1);
        if (vecs[v].gap && i == 3) idle(1);
      end
    end
    idle(3);
    check("a_no_frame_err_from_idle", 128'(fe_a), 128'(0));
    check("b_no_frame_err_from_idle", 128'(fe_b), 128'(0));

    // Latency: valid rises on the edge accepting bit 8.
    ia.out_ready = 1'b0;
    w = 8'hA5;
    q_a.push_back(w);
    for (int i = 0; i < 8; i++) begin
      drv(w[i], 1'b0, 1'b1, 1'b0);
      if (i == 7) begin
        @(negedge clock);
        check("a_before_last_bit", 128'({ia.out_valid, ia.busy}), 128'(2'b01));
      end
    end
    idle(1);
    @(negedge clock);
    check("a_latency", 128'({ia.out_valid, ia.busy, ia.out_data}), 128'({1'b1, 1'b0, 8'hA5}));
    ia.out_ready = 1'b1;
    idle(2);

    // Overrun: second word dropped while the slot is full.
    ia.out_ready = 1'b0;
    q_a.push_back(8'h3C);
    send_a(8'h3C);
    send_a(8'hC3);
    idle(1);
    @(negedge clock);
    check("a_overrun_hold", 128'({ia.out_valid, ia.overrun, ia.out_data}), 128'({1'b1, 1'b1, 8'h3C}));
    @(posedge clock); #1; ia.clr_ovr = 1'b1;
    @(posedge clock); #1; ia.clr_ovr = 1'b0;
    @(negedge clock);
    check("a_overrun_cleared", 128'({ia.out_valid, ia.overrun}), 128'(2'b10));
    ia.out_ready = 1'b1;
    idle(2);

    // Handshake on the same edge that completes the next word.
    ia.out_ready = 1'b0;
    q_a.push_back(8'h3C);
    send_a(8'h3C);
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      drv(w[i], 1'b0, 1'b1, 1'b0);
      if (i == 7) begin
        ia.out_ready = 1'b1;
        q_a.push_back(w);
      end
    end
    idle(1);
    @(negedge clock);
    check("a_simultaneous", 128'({ia.out_valid, ia.overrun, ia.out_data}), 128'({1'b1, 1'b0, 8'hC3}));
    idle(2);

    // Frame error: 3 bits then a restart carrying 0x5A.
    fe_a = 0;
    w = 8'h5A;
    q_a.push_back(w);
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drv(w[i], (i == 0), 1'b1, 1'b0);
    idle(3);
    check("a_frame_err_pulses", 128'(fe_a), 128'(1));

    // Asynchronous reset between edges with a held word and a partial word.
    ia.out_ready = 1'b0;
    send_a(8'h12);
    for (int i = 0; i < 5; i++) drv(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    #2;
    check("a_before_reset", 128'({ia.out_valid, ia.busy}), 128'(2'b11));
    rst_a = 1'b1;
    #1;
    check("a_async_reset", 128'({ia.out_data, ia.out_valid, ia.busy, ia.frame_err, ia.overrun}), 128'(0));
    @(negedge clock);
    rst_a = 1'b0;
    ia.out_ready = 1'b1;
    q_a.push_back(8'hFF);
    send_a(8'hFF);
    idle(3);

    // 128-bit word with only its end bits set, then a 127-bit partial cut by reset.
    wc = {1'b1, 126'd0, 1'b1};
    q_c.push_back(wc);
    for (int i = 0; i < 128; i++) drv_c(wc[i]);
    idle(3);
    for (int i = 0; i < 127; i++) drv_c(1'b1);
    idle(1);
    @(negedge clock);
    check("c_partial_no_valid", 128'({ic.out_valid, ic.busy}), 128'(2'b01));
    rst_c = 1'b1;
    #1;
    check("c_reset_partial", 128'({ic.out_valid, ic.busy}), 128'(0));
    @(posedge clock); #3;
    rst_c = 1'b0;
    idle(3);
    check("c_no_valid_after_reset", 128'(ic.out_valid), 128'(0));

    check("a_queue_drained", 128'(q_a.size()), 128'(0));
    check("b_queue_drained", 128'(q_b.size()), 128'(0));
    check("c_queue_drained", 128'(q_c.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
